// File: rtl/mem_access.sv
// mem_access: memory-access stage of the in-order RV32I pipeline.
// Loads and stores run byte-serially over an 8-bit RAM port whose read data
// arrives one cycle after its address. Non-memory records pass through with
// a single register of latency.
//
// state | meaning
// IDLE  | ready for a record; non-memory records complete here
// READ  | issuing load addresses and collecting returned bytes
// WRITE | issuing store bytes, one per cycle
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [5:0]  alu_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [31:0] rd_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_enable_i,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic        out_valid_o,
  output logic [31:0] rd_data_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_enable_o
);

  localparam logic [5:0] LB  = 6'd1;
  localparam logic [5:0] LH  = 6'd2;
  localparam logic [5:0] LW  = 6'd3;
  localparam logic [5:0] LBU = 6'd4;
  localparam logic [5:0] LHU = 6'd5;
  localparam logic [5:0] SB  = 6'd6;
  localparam logic [5:0] SH  = 6'd7;
  localparam logic [5:0] SW  = 6'd8;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  function automatic logic [2:0] op_bytes(input logic [5:0] op);
    case (op)
      LB, LBU, SB: op_bytes = 3'd1;
      LH, LHU, SH: op_bytes = 3'd2;
      default:     op_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    is_load = (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    is_store = (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] w);
    case (op)
      LB:      extend = {{24{w[7]}}, w[7:0]};
      LH:      extend = {{16{w[15]}}, w[15:0]};
      LBU:     extend = {24'd0, w[7:0]};
      LHU:     extend = {16'd0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rda_q, rda_d;
  logic        rde_q, rde_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_wr_q, ram_wr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        rd_enable_q, rd_enable_d;
  logic [2:0]  n_cur;
  logic [1:0]  idx;

  // Next-state, RAM bus and writeback computation
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rda_d       = rda_q;
    rde_d       = rde_q;
    cnt_d       = cnt_q + 3'd1;
    buf_d       = buf_q;
    ram_a_d     = '0;
    ram_dout_d  = '0;
    ram_wr_d    = 1'b0;
    out_valid_d = 1'b0;
    rd_data_d   = rd_data_q;
    rd_addr_d   = rd_addr_q;
    rd_enable_d = rd_enable_q;
    n_cur       = op_bytes(op_q);
    // cnt counts cycles since accept; the byte on ram_din is index cnt-2,
    // and adding 2 modulo 4 gives the same low bits.
    idx         = cnt_q[1:0] + 2'd2;
    unique case (state_q)
      IDLE: begin
        cnt_d = 3'd1;
        if (req_valid_i) begin
          op_d    = alu_op_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          rda_d   = rd_addr_i;
          rde_d   = rd_enable_i;
          buf_d   = '0;
          if (is_load(alu_op_i)) begin
            state_d = READ;
            ram_a_d = mem_addr_i;
          end else if (is_store(alu_op_i)) begin
            state_d    = WRITE;
            ram_a_d    = mem_addr_i;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata_i[7:0];
          end else begin
            out_valid_d = 1'b1;
            rd_data_d   = rd_data_i;
            rd_addr_d   = rd_addr_i;
            rd_enable_d = rd_enable_i;
          end
        end
      end
      READ: begin
        if (cnt_q < n_cur) ram_a_d = addr_q + {29'd0, cnt_q};
        if (cnt_q >= 3'd2) buf_d[{idx, 3'b000} +: 8] = ram_din;
        if (cnt_q == n_cur + 3'd1) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          rd_data_d   = extend(op_q, buf_d);
          rd_addr_d   = rda_q;
          rd_enable_d = rde_q;
        end
      end
      WRITE: begin
        if (cnt_q < n_cur) begin
          ram_a_d    = addr_q + {29'd0, cnt_q};
          ram_wr_d   = 1'b1;
          ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end else begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          rd_data_d   = '0;
          rd_addr_d   = rda_q;
          rd_enable_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rda_q       <= '0;
      rde_q       <= 1'b0;
      cnt_q       <= '0;
      buf_q       <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      rd_data_q   <= '0;
      rd_addr_q   <= '0;
      rd_enable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rda_q       <= rda_d;
      rde_q       <= rde_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      out_valid_q <= out_valid_d;
      rd_data_q   <= rd_data_d;
      rd_addr_q   <= rd_addr_d;
      rd_enable_q <= rd_enable_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign ram_a       = ram_a_q;
  assign ram_dout    = ram_dout_q;
  assign ram_wr      = ram_wr_q;
  assign out_valid_o = out_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_enable_o = rd_enable_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus random records, checked by a
// scoreboard against a byte-array memory model.
module tb_mem_access;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;
  localparam logic [5:0] OP_ADD = 6'd9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [5:0]  alu_op_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] rd_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_enable_i = 1'b0;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din = '0;
  logic        out_valid_o;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_enable_o;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .alu_op_i(alu_op_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
    .out_valid_o(out_valid_o), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
    .rd_enable_o(rd_enable_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        en;
    int          cyc;
    bit          store;
  } exp_t;
  exp_t exp_q[$];
  bit inflight_load = 1'b0;

  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  logic [31:0] a_log [64];
  logic [7:0]  d_log [64];
  logic        w_log [64];
  logic        r_log [64];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic int nbytes(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit is_ld(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic bit is_st(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Little-endian value of n bytes starting at addr, then extended.
  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr);
    logic [31:0] w = 0;
    for (int k = 0; k < nbytes(op); k++) w = w | (32'(ref_rd(addr + 32'(k))) << (8 * k));
    case (op)
      OP_LB: if (w[7]) w = w - 32'h100;
      OP_LH: if (w[15]) w = w - 32'h10000;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Byte-wide RAM: read data one cycle after the address
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_a] = ram_dout;
    ram_din <= ram_rd(ram_a);
  end

  // Monitor: logs the bus and scores every writeback pulse
  always @(negedge clk) begin
    cyc++;
    a_log[cyc & 63] = ram_a;
    d_log[cyc & 63] = ram_dout;
    w_log[cyc & 63] = ram_wr;
    r_log[cyc & 63] = req_ready_o;
    if (!rst) begin
      chk("valid_in_reset", 32'(out_valid_o), 32'd0);
    end else begin
      if (exp_q.size() == 0 && !out_valid_o) begin
        chk("idle_bus", {ram_a[31:1], ram_a[0] | ram_wr | (|ram_dout)}, 32'd0);
      end
      if (inflight_load && ram_wr) chk("wr_during_load", 32'(ram_wr), 32'd0);
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(out_valid_o), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          inflight_load = 1'b0;
          chk("wb_data", rd_data_o, e.data);
          chk("wb_en", 32'(rd_enable_o), 32'(e.en));
          if (!e.store) chk("wb_addr", 32'(rd_addr_o), 32'(e.addr));
          chk("wb_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    ram_mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdd, input logic [4:0] rda, input logic rde,
                      input bit expect_ready, output int acc);
    int guard = 0;
    exp_t e;
    @(negedge clk); #1;
    if (expect_ready) chk("ready_at_issue", 32'(req_ready_o), 32'd1);
    while (!req_ready_o && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    acc = cyc;
    if (!req_ready_o) begin
      chk("ready_timeout", 32'(req_ready_o), 32'd1);
      return;
    end
    alu_op_i = op; mem_addr_i = addr; mem_wdata_i = wdata;
    rd_data_i = rdd; rd_addr_i = rda; rd_enable_i = rde; req_valid_i = 1'b1;
    e.addr = rda;
    e.store = is_st(op);
    if (is_ld(op)) begin
      e.data = model_load(op, addr); e.en = rde; e.cyc = cyc + 1 + nbytes(op) + 1;
      inflight_load = 1'b1;
    end else if (is_st(op)) begin
      e.data = 0; e.en = 1'b0; e.cyc = cyc + 1 + nbytes(op);
      for (int k = 0; k < nbytes(op); k++) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
    end else begin
      e.data = rdd; e.en = rde; e.cyc = cyc + 1;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, "_rd_data"}, rd_data_o, 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr_o), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_enable_o), 32'd0);
    chk({tag, "_ram_a"}, ram_a, 32'd0);
    chk({tag, "_ram_dout"}, 32'(ram_dout), 32'd0);
    chk({tag, "_ram_wr"}, 32'(ram_wr), 32'd0);
  endtask

  initial begin
    int c, cnt, guard;
    logic [7:0] old2, old3;
    logic [5:0] op;
    logic [31:0] addr;

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("reset");
    rst = 1'b1;

    // three back-to-back pass-through records
    send(OP_ADD, 0, 0, 32'd1, 5'd1, 1'b1, 1'b1, c);
    send(OP_ADD, 0, 0, 32'd2, 5'd2, 1'b1, 1'b1, c);
    send(OP_ADD, 0, 0, 32'd3, 5'd3, 1'b1, 1'b1, c);
    wait_idle();

    // word load, address sequence and busy window (n+1 = 5 cycles)
    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    send(OP_LW, 32'h100, 0, 0, 5'd7, 1'b1, 1'b1, c);
    wait_idle();
    chk("lw_model", model_load(OP_LW, 32'h100), 32'h12345678);
    for (int k = 0; k < 4; k++) chk("lw_ram_a", a_log[(c + 1 + k) & 63], 32'h100 + 32'(k));
    chk("lw_ram_a_after", a_log[(c + 5) & 63], 32'd0);
    cnt = 0;
    for (int j = 1; j <= 7; j++) if (!r_log[(c + j) & 63]) cnt++;
    chk("lw_busy_cycles", 32'(cnt), 32'd5);

    // narrow loads and their extension
    poke(32'h200, 8'h80);
    poke(32'h300, 8'h01); poke(32'h301, 8'h80);
    send(OP_LB,  32'h200, 0, 0, 5'd8, 1'b1, 1'b1, c);
    send(OP_LBU, 32'h200, 0, 0, 5'd9, 1'b1, 1'b0, c);
    send(OP_LHU, 32'h300, 0, 0, 5'd10, 1'b1, 1'b0, c);
    send(OP_LH,  32'h300, 0, 0, 5'd11, 1'b0, 1'b0, c);
    wait_idle();

    // misaligned halfword store crossing 0x200
    send(OP_SH, 32'h1FF, 32'hABCD1234, 0, 5'd12, 1'b1, 1'b1, c);
    wait_idle();
    chk("sh_a0", a_log[(c + 1) & 63], 32'h1FF);
    chk("sh_d0", 32'(d_log[(c + 1) & 63]), 32'h34);
    chk("sh_a1", a_log[(c + 2) & 63], 32'h200);
    chk("sh_d1", 32'(d_log[(c + 2) & 63]), 32'h12);
    cnt = 0;
    for (int j = 1; j <= 4; j++) if (w_log[(c + j) & 63]) cnt++;
    chk("sh_wr_cycles", 32'(cnt), 32'd2);
    send(OP_LHU, 32'h1FF, 0, 0, 5'd13, 1'b1, 1'b1, c);
    wait_idle();

    // load wrapping past the top of the address space
    poke(32'hFFFFFFFE, 8'h11); poke(32'hFFFFFFFF, 8'h22); poke(32'h0, 8'h33); poke(32'h1, 8'h44);
    send(OP_LW, 32'hFFFFFFFE, 0, 0, 5'd14, 1'b1, 1'b1, c);
    wait_idle();
    chk("wrap_a0", a_log[(c + 1) & 63], 32'hFFFFFFFE);
    chk("wrap_a1", a_log[(c + 2) & 63], 32'hFFFFFFFF);
    chk("wrap_a2", a_log[(c + 3) & 63], 32'h0);
    chk("wrap_a3", a_log[(c + 4) & 63], 32'h1);

    // reset during the third byte of a word store
    old2 = ref_rd(32'h402); old3 = ref_rd(32'h403);
    send(OP_SW, 32'h400, 32'hDEADBEEF, 0, 5'd15, 1'b1, 1'b1, c);
    guard = 0;
    while (cyc < c + 3 && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("rst_at_byte2_wr", 32'(ram_wr), 32'd1);
    chk("rst_at_byte2_a", ram_a, 32'h402);
    rst = 1'b0;
    #1 chk_reset_outputs("midrst");
    exp_q.delete();
    inflight_load = 1'b0;
    ref_mem[32'h402] = old2;
    ref_mem[32'h403] = old3;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    send(OP_LB, 32'h401, 0, 0, 5'd16, 1'b1, 1'b1, c);
    send(OP_LW, 32'h400, 0, 0, 5'd17, 1'b1, 1'b0, c);
    wait_idle();

    // random mix of records
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: op = OP_LB;  1: op = OP_LH;  2: op = OP_LW;  3: op = OP_LBU;
        4: op = OP_LHU; 5: op = OP_SB;  6: op = OP_SH;  7: op = OP_SW;
        default: op = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(9, 63));
      endcase
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 7));
      else addr = 32'h1000 + 32'($urandom_range(0, 63));
      send(op, addr, $urandom, $urandom, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 1'b0, c);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_idle();

    foreach (ref_mem[a]) chk("ram_final", 32'(ram_rd(a)), 32'(ref_mem[a]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
